// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: FSM encoding and the tracked
// pipe-entry record.
package hazard_pkg;

    // Widest register index the entry record can hold; REG_AW must not exceed it.
    localparam int RD_W_MAX = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                is_load;
    } pipe_entry_t;

    localparam pipe_entry_t BUBBLE = '{valid: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Per-source producer search: reports the youngest pipe stage whose
// destination matches one decode source operand.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  pipe_entry_t [FWD_DEPTH-1:0] i_pipe,
    input  logic                        i_id_valid,
    input  logic [REG_AW-1:0]           i_src,
    input  logic                        i_used,
    output logic                        o_hit,
    output logic                        o_is_load,
    output logic [SEL_W-1:0]            o_stage
);

    logic [RD_W_MAX-1:0] w_src_ext;

    assign w_src_ext = RD_W_MAX'(i_src);

    // Scan oldest to youngest so the smallest matching stage is the one kept.
    always_comb begin
        o_hit     = 1'b0;
        o_is_load = 1'b0;
        o_stage   = '0;
        if (i_id_valid && i_used && (i_src != '0)) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (i_pipe[k].valid && (i_pipe[k].rd == w_src_ext)) begin
                    o_hit     = 1'b1;
                    o_is_load = i_pipe[k].is_load;
                    o_stage   = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations, selects
// forwarding sources and inserts load-use bubbles.
//
// state    | meaning
// ST_RUN   | no load-use bubble was issued on the previous edge
// ST_STALL | a load-use bubble was issued on the previous edge
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 2,
    parameter int CNT_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid,
    input  logic [REG_AW-1:0]                  id_rs1,
    input  logic [REG_AW-1:0]                  id_rs2,
    input  logic                               id_rs1_used,
    input  logic                               id_rs2_used,
    input  logic [REG_AW-1:0]                  id_rd,
    input  logic                               id_rd_we,
    input  logic                               id_is_load,
    input  logic                               flush,
    output logic                               stall,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel1,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel2,
    output logic [CNT_W-1:0]                   stall_cnt,
    output logic                               busy_state
);

    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    localparam logic [SEL_W-1:0] LOAD_LAT_S = SEL_W'(LOAD_LAT);

    pipe_entry_t [FWD_DEPTH-1:0] r_pipe;
    state_t                      r_state;
    state_t                      w_state_nxt;
    pipe_entry_t                 w_issue;
    logic                        w_hit1, w_hit2;
    logic                        w_ld1, w_ld2;
    logic [SEL_W-1:0]            w_stage1, w_stage2;
    logic                        w_lu1, w_lu2;

    hazard_match #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_rs1 (
        .i_pipe     (r_pipe),
        .i_id_valid (id_valid),
        .i_src      (id_rs1),
        .i_used     (id_rs1_used),
        .o_hit      (w_hit1),
        .o_is_load  (w_ld1),
        .o_stage    (w_stage1)
    );

    hazard_match #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_rs2 (
        .i_pipe     (r_pipe),
        .i_id_valid (id_valid),
        .i_src      (id_rs2),
        .i_used     (id_rs2_used),
        .o_hit      (w_hit2),
        .o_is_load  (w_ld2),
        .o_stage    (w_stage2)
    );

    // A load younger than LOAD_LAT has no data yet; hold decode until it ages.
    assign w_lu1 = w_hit1 && w_ld1 && (w_stage1 < LOAD_LAT_S);
    assign w_lu2 = w_hit2 && w_ld2 && (w_stage2 < LOAD_LAT_S);

    assign stall      = id_valid && !flush && (w_lu1 || w_lu2);
    assign fwd_sel1   = w_stage1;
    assign fwd_sel2   = w_stage2;
    assign busy_state = (r_state == ST_STALL);

    always_comb begin
        w_issue = BUBBLE;
        if (!stall && !flush) begin
            w_issue.valid   = id_valid && id_rd_we && (id_rd != '0);
            w_issue.rd      = RD_W_MAX'(id_rd);
            w_issue.is_load = id_is_load;
        end
    end

    // Flush kills both the decode slot and whatever sat in stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_pipe[k] <= ((k == 1) && flush) ? BUBBLE : r_pipe[k-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (!flush && stall) begin
            w_state_nxt = ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
